// File: rtl/matrix_cmd_seq_pkg.sv
// Shared definitions for the matrix command path (sequencer, stack, decoder).
//   - opcode constants OP_NOP .. OP_MULT
//   - mode constants MODE_MODELVIEW / MODE_PROJECTION
//   - ROW_W: one matrix row (4 x IEEE-754 single)
//   - IDENT_ROW0..3: rows of the 4x4 identity matrix
//   - seq_state_t: command sequencer states
package matrix_cmd_seq_pkg;

   localparam int ROW_W = 128;

   localparam logic [2:0] OP_NOP     = 3'd0;
   localparam logic [2:0] OP_LOAD_ID = 3'd1;
   localparam logic [2:0] OP_LOAD    = 3'd2;
   localparam logic [2:0] OP_PUSH    = 3'd3;
   localparam logic [2:0] OP_POP     = 3'd4;
   localparam logic [2:0] OP_MULT    = 3'd5;

   localparam logic MODE_MODELVIEW  = 1'b0;
   localparam logic MODE_PROJECTION = 1'b1;

   localparam logic [ROW_W-1:0] IDENT_ROW0 = 128'h3F800000_00000000_00000000_00000000;
   localparam logic [ROW_W-1:0] IDENT_ROW1 = 128'h00000000_3F800000_00000000_00000000;
   localparam logic [ROW_W-1:0] IDENT_ROW2 = 128'h00000000_00000000_3F800000_00000000;
   localparam logic [ROW_W-1:0] IDENT_ROW3 = 128'h00000000_00000000_00000000_3F800000;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_COLLECT   = 4'd1,
      ST_ISSUE0    = 4'd2,
      ST_ISSUE1    = 4'd3,
      ST_ISSUE2    = 4'd4,
      ST_ISSUE3    = 4'd5,
      ST_MUL_START = 4'd6,
      ST_MUL_WAIT  = 4'd7,
      ST_WRITE     = 4'd8
   } seq_state_t;

endpackage

// File: rtl/matrix_row_buf.sv
// 4 x ROW_W row buffer for the command sequencer.
// Ports:
//   clk, reset        clock, asynchronous active-high reset (clears rows and index)
//   load_peek         parallel load of peek_0..3 into rows 0..3, index back to 0
//   peek_0..peek_3    stack top rows
//   wr_en, wr_data    sequential write at wr_idx, index advances (wraps after row 3)
//   wr_idx            next row to be written
//   rd_idx, rd_data   indexed read
module matrix_row_buf #(
   parameter int ROW_W = 128
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_peek,
   input  logic [ROW_W-1:0] peek_0,
   input  logic [ROW_W-1:0] peek_1,
   input  logic [ROW_W-1:0] peek_2,
   input  logic [ROW_W-1:0] peek_3,
   input  logic             wr_en,
   input  logic [ROW_W-1:0] wr_data,
   output logic [1:0]       wr_idx,
   input  logic [1:0]       rd_idx,
   output logic [ROW_W-1:0] rd_data
);

   logic [ROW_W-1:0] rows [4];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) rows[i] <= '0;
         wr_idx <= 2'd0;
      end else if (load_peek) begin
         rows[0] <= peek_0;
         rows[1] <= peek_1;
         rows[2] <= peek_2;
         rows[3] <= peek_3;
         wr_idx  <= 2'd0;
      end else if (wr_en) begin
         rows[wr_idx] <= wr_data;
         wr_idx       <= wr_idx + 2'd1;
      end
   end

   assign rd_data = rows[rd_idx];

endmodule

// File: rtl/matrix_cmd_seq.sv
// Command sequencer in front of the matrix stack controller.
// Accepts LOAD_ID / LOAD / PUSH / POP / MULT, drives the stack strobes, row bus
// and mode line, tracks per-mode stack depth and sequences the 4x4 multiplier.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op/cmd_mode   command port
//   data_valid/data_ready/data_in  operand row port (row 0 first)
//   stall                          downstream full; only gates command start
//   peek_in_0..3                   stack top rows
//   matrix_mode, load_id_en, load_en, pop_en, write_en, row_out   to the stack
//   mult_start, mult_done          multiplier handshake
//   busy, err_overflow, err_underflow, err_clr   status
//   dbg_state, dbg_depth_mv, dbg_depth_pj        FSM state and depth counters
// Optional: MATRIX_SEQ_STATS_EN adds stat_cmds / stat_errs counters.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid may be held without ready, and the data must stay stable until
// the transfer edge.
module matrix_cmd_seq #(
   parameter int STACK_DEPTH = 2,
   parameter int ROW_W       = matrix_cmd_seq_pkg::ROW_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic             cmd_mode,
   input  logic             data_valid,
   output logic             data_ready,
   input  logic [ROW_W-1:0] data_in,
   input  logic             stall,
   input  logic [ROW_W-1:0] peek_in_0,
   input  logic [ROW_W-1:0] peek_in_1,
   input  logic [ROW_W-1:0] peek_in_2,
   input  logic [ROW_W-1:0] peek_in_3,
   output logic             matrix_mode,
   output logic             load_id_en,
   output logic             load_en,
   output logic             pop_en,
   output logic             write_en,
   output logic [ROW_W-1:0] row_out,
   output logic             mult_start,
   input  logic             mult_done,
   output logic             busy,
   output logic             err_overflow,
   output logic             err_underflow,
   input  logic             err_clr,
   output logic [3:0]       dbg_state,
   output logic [1:0]       dbg_depth_mv,
   output logic [1:0]       dbg_depth_pj
`ifdef MATRIX_SEQ_STATS_EN
   ,
   output logic [15:0]      stat_cmds,
   output logic [7:0]       stat_errs
`endif
);

   import matrix_cmd_seq_pkg::*;

   localparam logic [1:0] DEPTH_MAX = 2'(STACK_DEPTH);

   seq_state_t       state, state_nxt;
   logic             discard_q, discard_nxt;
   logic             mult_q, mult_nxt;
   logic [1:0]       depth_mv, depth_pj;
   logic [1:0]       depth_cmd, depth_cur;
   logic             accept, row_take;
   logic             load_peek;
   logic             load_id_nxt, pop_nxt;
   logic             ovf_set, unf_set;
   logic             depth_inc, depth_dec;
   logic [1:0]       wr_idx, rd_idx;
   logic [ROW_W-1:0] buf_rd, row_nxt;
   logic             issue_nxt;

   assign cmd_ready = (state == ST_IDLE) && !stall && !reset;
   assign accept    = cmd_valid && cmd_ready;
   // data_ready is registered from the next state, so it is high exactly in COLLECT.
   assign row_take  = (state == ST_COLLECT) && data_valid && data_ready;

   // Overflow/underflow checks at acceptance use the incoming mode; the ISSUE
   // increment uses the mode latched at acceptance.
   assign depth_cmd = cmd_mode    ? depth_pj : depth_mv;
   assign depth_cur = matrix_mode ? depth_pj : depth_mv;

   assign dbg_state    = state;
   assign dbg_depth_mv = depth_mv;
   assign dbg_depth_pj = depth_pj;

   matrix_row_buf #(.ROW_W(ROW_W)) u_buf (
      .clk       (clk),
      .reset     (reset),
      .load_peek (load_peek),
      .peek_0    (peek_in_0),
      .peek_1    (peek_in_1),
      .peek_2    (peek_in_2),
      .peek_3    (peek_in_3),
      .wr_en     (row_take),
      .wr_data   (data_in),
      .wr_idx    (wr_idx),
      .rd_idx    (rd_idx),
      .rd_data   (buf_rd)
   );

   always_comb begin
      state_nxt   = state;
      discard_nxt = discard_q;
      mult_nxt    = mult_q;
      load_peek   = 1'b0;
      load_id_nxt = 1'b0;
      pop_nxt     = 1'b0;
      ovf_set     = 1'b0;
      unf_set     = 1'b0;
      depth_inc   = 1'b0;
      depth_dec   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_LOAD_ID: load_id_nxt = 1'b1;
                  OP_POP: begin
                     if (depth_cmd == 2'd1) begin
                        unf_set = 1'b1;
                     end else begin
                        pop_nxt   = 1'b1;
                        depth_dec = 1'b1;
                     end
                  end
                  OP_PUSH: begin
                     if (depth_cmd == DEPTH_MAX) begin
                        ovf_set = 1'b1;
                     end else begin
                        load_peek = 1'b1;
                        state_nxt = ST_ISSUE0;
                     end
                  end
                  OP_LOAD: begin
                     // A rejected LOAD still drains its four operand rows.
                     ovf_set     = (depth_cmd == DEPTH_MAX);
                     discard_nxt = ovf_set;
                     mult_nxt    = 1'b0;
                     state_nxt   = ST_COLLECT;
                  end
                  OP_MULT: begin
                     discard_nxt = 1'b0;
                     mult_nxt    = 1'b1;
                     state_nxt   = ST_COLLECT;
                  end
                  default: ;
               endcase
            end
         end
         ST_COLLECT: begin
            if (row_take && (wr_idx == 2'd3)) begin
               if (discard_q)   state_nxt = ST_IDLE;
               else if (mult_q) state_nxt = ST_MUL_START;
               else             state_nxt = ST_ISSUE0;
            end
         end
         ST_ISSUE0: begin
            depth_inc = 1'b1;
            state_nxt = ST_ISSUE1;
         end
         ST_ISSUE1:    state_nxt = ST_ISSUE2;
         ST_ISSUE2:    state_nxt = ST_ISSUE3;
         ST_ISSUE3:    state_nxt = ST_IDLE;
         ST_MUL_START: state_nxt = ST_MUL_WAIT;
         ST_MUL_WAIT:  if (mult_done) state_nxt = ST_WRITE;
         ST_WRITE:     state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state.
   always_comb begin
      rd_idx    = 2'd0;
      issue_nxt = 1'b0;
      case (state_nxt)
         ST_ISSUE0: issue_nxt = 1'b1;
         ST_ISSUE1: begin rd_idx = 2'd1; issue_nxt = 1'b1; end
         ST_ISSUE2: begin rd_idx = 2'd2; issue_nxt = 1'b1; end
         ST_ISSUE3: begin rd_idx = 2'd3; issue_nxt = 1'b1; end
         default: ;
      endcase
      row_nxt = '0;
      // On PUSH the buffer loads on the same edge, so row 0 bypasses it.
      if (issue_nxt) row_nxt = load_peek ? peek_in_0 : buf_rd;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         discard_q     <= 1'b0;
         mult_q        <= 1'b0;
         matrix_mode   <= MODE_MODELVIEW;
         load_id_en    <= 1'b0;
         load_en       <= 1'b0;
         pop_en        <= 1'b0;
         write_en      <= 1'b0;
         mult_start    <= 1'b0;
         data_ready    <= 1'b0;
         busy          <= 1'b0;
         row_out       <= '0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
         depth_mv      <= 2'd1;
         depth_pj      <= 2'd1;
      end else begin
         state      <= state_nxt;
         discard_q  <= discard_nxt;
         mult_q     <= mult_nxt;
         load_id_en <= load_id_nxt;
         pop_en     <= pop_nxt;
         load_en    <= (state_nxt == ST_ISSUE0);
         write_en   <= (state_nxt == ST_WRITE);
         mult_start <= (state_nxt == ST_MUL_START);
         data_ready <= (state_nxt == ST_COLLECT);
         busy       <= (state_nxt != ST_IDLE);
         row_out    <= row_nxt;
         if (accept) matrix_mode <= cmd_mode;

         // A new error beats a simultaneous clear.
         if (ovf_set)      err_overflow <= 1'b1;
         else if (err_clr) err_overflow <= 1'b0;
         if (unf_set)      err_underflow <= 1'b1;
         else if (err_clr) err_underflow <= 1'b0;

         if (depth_dec) begin
            if (cmd_mode) depth_pj <= depth_pj - 2'd1;
            else          depth_mv <= depth_mv - 2'd1;
         end
         if (depth_inc && (depth_cur != DEPTH_MAX)) begin
            if (matrix_mode) depth_pj <= depth_pj + 2'd1;
            else             depth_mv <= depth_mv + 2'd1;
         end
      end
   end

`ifdef MATRIX_SEQ_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_cmds <= '0;
         stat_errs <= '0;
      end else begin
         if (accept && (cmd_op >= OP_LOAD_ID) && (cmd_op <= OP_MULT))
            stat_cmds <= stat_cmds + 16'd1;
         if (ovf_set || unf_set)
            stat_errs <= stat_errs + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_matrix_cmd_seq.sv
module tb_matrix_cmd_seq;
   import matrix_cmd_seq_pkg::*;

   localparam int W = 128;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [2:0]   cmd_op = 3'd0;
   logic         cmd_mode = 1'b0;
   logic         data_valid = 1'b0;
   logic         data_ready;
   logic [W-1:0] data_in = '0;
   logic         stall = 1'b0;
   logic [W-1:0] peek_in_0 = '0, peek_in_1 = '0, peek_in_2 = '0, peek_in_3 = '0;
   logic         matrix_mode, load_id_en, load_en, pop_en, write_en;
   logic [W-1:0] row_out;
   logic         mult_start;
   logic         mult_done = 1'b0;
   logic         busy, err_overflow, err_underflow;
   logic         err_clr = 1'b0;
   logic [3:0]   dbg_state;
   logic [1:0]   dbg_depth_mv, dbg_depth_pj;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_exp;
   int issue_cnt = 0;

   matrix_cmd_seq #(.STACK_DEPTH(2), .ROW_W(W)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_mode(cmd_mode),
      .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
      .stall(stall),
      .peek_in_0(peek_in_0), .peek_in_1(peek_in_1), .peek_in_2(peek_in_2), .peek_in_3(peek_in_3),
      .matrix_mode(matrix_mode), .load_id_en(load_id_en), .load_en(load_en),
      .pop_en(pop_en), .write_en(write_en), .row_out(row_out),
      .mult_start(mult_start), .mult_done(mult_done), .busy(busy),
      .err_overflow(err_overflow), .err_underflow(err_underflow), .err_clr(err_clr),
      .dbg_state(dbg_state), .dbg_depth_mv(dbg_depth_mv), .dbg_depth_pj(dbg_depth_pj)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Scoreboard: every issue sequence (load_en + 3 rows) pops expected rows.
   always @(posedge clk) begin
      #1;
      if (reset) begin
         issue_cnt = 0;
      end else if (load_en || issue_cnt != 0) begin
         checks++;
         if (load_en !== (issue_cnt == 0)) begin
            errors++;
            $display("FAIL issue_strobe: load_en=%b at row %0d, required %b", load_en, issue_cnt, issue_cnt == 0);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL issue_unexpected: row_out=%h with no row expected", row_out);
         end else begin
            mon_exp = exp_q.pop_front();
            if (row_out !== mon_exp) begin
               errors++;
               $display("FAIL issue_row%0d: row_out=%h required %h", issue_cnt, row_out, mon_exp);
            end
         end
         issue_cnt = (issue_cnt + 1) % 4;
      end
   end

   // drivers (called at a falling edge, return at the falling edge after the transfer)
   task automatic send_cmd(input logic [2:0] op, input logic mode);
      int n = 0;
      cmd_op = op; cmd_mode = mode; cmd_valid = 1'b1;
      #1;
      while (!cmd_ready && n < 50) begin @(negedge clk); #1; n++; end
      checks++;
      if (!cmd_ready) begin
         errors++;
         $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic send_row(input logic [W-1:0] row, input int gap);
      int n = 0;
      data_valid = 1'b0;
      repeat (gap) @(negedge clk);
      data_in = row; data_valid = 1'b1;
      #1;
      while (!data_ready && n < 50) begin @(negedge clk); #1; n++; end
      checks++;
      if (!data_ready) begin
         errors++;
         $display("FAIL row_accept: data_ready=%b after %0d cycles, required 1", data_ready, n);
      end
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   task automatic test_reset();
      cmd_valid = 1'b1; cmd_op = OP_LOAD_ID;
      repeat (3) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready); end
      checks++;
      if ({load_id_en, load_en, pop_en, write_en, mult_start, data_ready, busy, matrix_mode, err_overflow, err_underflow} !== 10'b0) begin
         errors++; $display("FAIL reset_outputs: got %b required 0", {load_id_en, load_en, pop_en, write_en, mult_start, data_ready, busy, matrix_mode, err_overflow, err_underflow});
      end
      checks++;
      if (row_out !== '0) begin errors++; $display("FAIL reset_row_out: got %h required 0", row_out); end
      checks++;
      if (dbg_depth_mv !== 2'd1 || dbg_depth_pj !== 2'd1 || dbg_state !== 4'd0) begin
         errors++; $display("FAIL reset_depth_state: mv=%0d pj=%0d st=%0d required 1 1 0", dbg_depth_mv, dbg_depth_pj, dbg_state);
      end
      cmd_valid = 1'b0; reset = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_cmd_ready: got %b required 1", cmd_ready); end
      @(negedge clk);
   endtask

   task automatic test_push();
      peek_in_0 = IDENT_ROW0; peek_in_1 = IDENT_ROW1; peek_in_2 = IDENT_ROW2; peek_in_3 = IDENT_ROW3;
      exp_q.push_back(IDENT_ROW0); exp_q.push_back(IDENT_ROW1);
      exp_q.push_back(IDENT_ROW2); exp_q.push_back(IDENT_ROW3);
      send_cmd(OP_PUSH, MODE_MODELVIEW);
      // peek changes after acceptance must not reach the row bus
      peek_in_0 = {4{$urandom()}}; peek_in_1 = {4{$urandom()}};
      peek_in_2 = {4{$urandom()}}; peek_in_3 = {4{$urandom()}};
      checks++;
      if (load_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL push_load_en: load_en=%b busy=%b required 1 1", load_en, busy); end
      @(negedge clk);
      checks++;
      if (load_en !== 1'b0) begin errors++; $display("FAIL push_load_en_width: got %b required 0", load_en); end
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || dbg_depth_mv !== 2'd2) begin errors++; $display("FAIL push_done: busy=%b depth_mv=%0d required 0 2", busy, dbg_depth_mv); end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL push_rows_left: %0d rows not issued, required 0", exp_q.size()); end
   endtask

   task automatic test_overflow_underflow();
      send_cmd(OP_PUSH, MODE_MODELVIEW);
      checks++;
      if (err_overflow !== 1'b1 || load_en !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL push_overflow: ovf=%b load_en=%b cmd_ready=%b required 1 0 1", err_overflow, load_en, cmd_ready);
      end
      send_cmd(OP_POP, MODE_MODELVIEW);
      checks++;
      if (pop_en !== 1'b1 || dbg_depth_mv !== 2'd1) begin errors++; $display("FAIL pop_ok: pop_en=%b depth_mv=%0d required 1 1", pop_en, dbg_depth_mv); end
      send_cmd(OP_POP, MODE_MODELVIEW);
      checks++;
      if (pop_en !== 1'b0 || err_underflow !== 1'b1 || dbg_depth_mv !== 2'd1) begin
         errors++; $display("FAIL pop_underflow: pop_en=%b unf=%b depth_mv=%0d required 0 1 1", pop_en, err_underflow, dbg_depth_mv);
      end
      // clear together with a fresh underflow: the new error survives
      err_clr = 1'b1;
      send_cmd(OP_POP, MODE_MODELVIEW);
      err_clr = 1'b0;
      checks++;
      if (err_underflow !== 1'b1 || err_overflow !== 1'b0) begin
         errors++; $display("FAIL clr_vs_set: unf=%b ovf=%b required 1 0", err_underflow, err_overflow);
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if (err_underflow !== 1'b0) begin errors++; $display("FAIL err_clr: unf=%b required 0", err_underflow); end
   endtask

   task automatic test_load_gaps_stall();
      logic [W-1:0] rows [4];
      rows[0] = 128'h3B4CCCCD_00000000_00000000_00000000;
      rows[1] = 128'h00000000_3B888889_00000000_00000000;
      rows[2] = 128'h00000000_00000000_BB88D180_00000000;
      rows[3] = 128'h00000000_00000000_00000000_3F800000;
      for (int i = 0; i < 4; i++) exp_q.push_back(rows[i]);
      send_cmd(OP_LOAD, MODE_PROJECTION);
      checks++;
      if (data_ready !== 1'b1 || matrix_mode !== 1'b1) begin errors++; $display("FAIL load_collect: data_ready=%b mode=%b required 1 1", data_ready, matrix_mode); end
      for (int i = 0; i < 4; i++) send_row(rows[i], 2);
      for (int i = 0; i < 6; i++) begin
         stall = ~stall;
         @(negedge clk);
      end
      stall = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || dbg_depth_pj !== 2'd2 || dbg_depth_mv !== 2'd1) begin
         errors++; $display("FAIL load_depth: busy=%b pj=%0d mv=%0d required 0 2 1", busy, dbg_depth_pj, dbg_depth_mv);
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL load_rows_left: %0d rows not issued, required 0", exp_q.size()); end
   endtask

   task automatic test_load_overflow();
      send_cmd(OP_LOAD, MODE_PROJECTION);
      checks++;
      if (err_overflow !== 1'b1 || data_ready !== 1'b1) begin errors++; $display("FAIL load_ovf_flag: ovf=%b data_ready=%b required 1 1", err_overflow, data_ready); end
      for (int i = 0; i < 4; i++) send_row({4{$urandom()}}, $urandom_range(0, 2));
      checks++;
      if (busy !== 1'b0 || data_ready !== 1'b0 || load_en !== 1'b0 || dbg_depth_pj !== 2'd2) begin
         errors++; $display("FAIL load_ovf_drain: busy=%b data_ready=%b load_en=%b pj=%0d required 0 0 0 2", busy, data_ready, load_en, dbg_depth_pj);
      end
      @(negedge clk);
   endtask

   task automatic test_mult();
      int starts = 0, early_wr = 0, bad_mode = 0;
      send_cmd(OP_MULT, MODE_MODELVIEW);
      for (int i = 0; i < 4; i++) send_row({4{$urandom()}}, 0);
      checks++;
      if (mult_start !== 1'b1) begin errors++; $display("FAIL mult_start: got %b required 1", mult_start); end
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (mult_start) starts++;
         if (write_en) early_wr++;
         if (matrix_mode !== 1'b0) bad_mode++;
      end
      mult_done = 1'b1;
      @(negedge clk);
      mult_done = 1'b0;
      checks++;
      if (write_en !== 1'b1) begin errors++; $display("FAIL mult_write_en: got %b required 1", write_en); end
      @(negedge clk);
      checks++;
      if (write_en !== 1'b0 || busy !== 1'b0 || dbg_depth_mv !== 2'd1) begin
         errors++; $display("FAIL mult_done: write_en=%b busy=%b mv=%0d required 0 0 1", write_en, busy, dbg_depth_mv);
      end
      checks++;
      if (starts != 0 || early_wr != 0 || bad_mode != 0) begin
         errors++; $display("FAIL mult_wait: extra_starts=%0d early_writes=%0d mode_changes=%0d required 0 0 0", starts, early_wr, bad_mode);
      end
   endtask

   task automatic test_stall();
      int bad = 0;
      stall = 1'b1; cmd_valid = 1'b1; cmd_op = OP_LOAD_ID; cmd_mode = MODE_PROJECTION;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (cmd_ready !== 1'b0 || load_id_en !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL stall_block: %0d cycles with cmd_ready or strobe, required 0", bad); end
      stall = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL stall_release: cmd_ready=%b required 1", cmd_ready); end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (load_id_en !== 1'b1 || matrix_mode !== 1'b1) begin errors++; $display("FAIL stall_accept: load_id_en=%b mode=%b required 1 1", load_id_en, matrix_mode); end
   endtask

   task automatic test_back_to_back();
      send_cmd(OP_LOAD_ID, MODE_MODELVIEW);
      checks++;
      if (load_id_en !== 1'b1 || dbg_depth_mv !== 2'd1) begin errors++; $display("FAIL b2b_load_id: load_id_en=%b mv=%0d required 1 1", load_id_en, dbg_depth_mv); end
      send_cmd(3'd7, MODE_PROJECTION);
      checks++;
      if ({load_id_en, load_en, pop_en, write_en, mult_start, busy} !== 6'b0 || matrix_mode !== 1'b1) begin
         errors++; $display("FAIL b2b_reserved: strobes=%b mode=%b required 0 1", {load_id_en, load_en, pop_en, write_en, mult_start, busy}, matrix_mode);
      end
      send_cmd(OP_POP, MODE_PROJECTION);
      checks++;
      if (pop_en !== 1'b1 || dbg_depth_pj !== 2'd1) begin errors++; $display("FAIL b2b_pop_pj: pop_en=%b pj=%0d required 1 1", pop_en, dbg_depth_pj); end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      peek_in_0 = {4{$urandom()}}; peek_in_1 = {4{$urandom()}};
      peek_in_2 = {4{$urandom()}}; peek_in_3 = {4{$urandom()}};
      exp_q.push_back(peek_in_0); exp_q.push_back(peek_in_1);
      exp_q.push_back(peek_in_2); exp_q.push_back(peek_in_3);
      send_cmd(OP_PUSH, MODE_PROJECTION);
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({load_id_en, load_en, pop_en, write_en, mult_start, data_ready, busy, matrix_mode, err_overflow, err_underflow, cmd_ready} !== 11'b0) begin
         errors++; $display("FAIL midreset_outputs: got %b required 0", {load_id_en, load_en, pop_en, write_en, mult_start, data_ready, busy, matrix_mode, err_overflow, err_underflow, cmd_ready});
      end
      checks++;
      if (row_out !== '0 || dbg_depth_mv !== 2'd1 || dbg_depth_pj !== 2'd1) begin
         errors++; $display("FAIL midreset_state: row_out=%h mv=%0d pj=%0d required 0 1 1", row_out, dbg_depth_mv, dbg_depth_pj);
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      send_cmd(OP_LOAD_ID, MODE_MODELVIEW);
      if (load_id_en) pulses++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (load_id_en) pulses++;
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL midreset_load_id: %0d pulses required 1", pulses); end
   endtask

   initial begin
      test_reset();
      test_push();
      test_overflow_underflow();
      test_load_gaps_stall();
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      test_load_overflow();
      test_mult();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: %0d rows pending required 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
